la_capture_core: RTL

LA_CAPTURE_CORE -- requirements
Module: la_capture_core

---
 rtl/la_capture_core_pkg.sv | 24 ++
 rtl/la_capture_core_if.sv | 26 ++
 rtl/la_capture_core_sample_ram.sv | 33 +++
 rtl/la_capture_core.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/la_capture_core_pkg.sv
// Shared types for the logic-analyzer capture core: FSM states, trigger modes
// and the select-width helper used to size the trigger channel port.
package la_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } la_state_t;

  typedef enum logic [1:0] {
    TRIG_RISE   = 2'b00,
    TRIG_FALL   = 2'b01,
    TRIG_EITHER = 2'b10,
    TRIG_IMMED  = 2'b11
  } trig_mode_t;

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_capture_core_if.sv
// Readout bus of the capture core: request side (index, zoom, offset) and the
// returned sample with its qualifier.
interface la_capture_core_if #(
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 13,
  parameter int ZOOM_W     = 4
);

  logic                  rd_req;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [ZOOM_W-1:0]     zoom;
  logic [DEPTH_LOG2-1:0] offset;
  logic [CHANNELS-1:0]   dout;
  logic                  rd_valid;

  modport master (
    output rd_req, rd_idx, zoom, offset,
    input  dout, rd_valid
  );

  modport slave (
    input  rd_req, rd_idx, zoom, offset,
    output dout, rd_valid
  );

endinterface

// File: rtl/la_capture_core_sample_ram.sv
// Single-port sample memory: synchronous read plus a registered output stage,
// giving two cycles from address to data. Contents survive reset.
module la_sample_ram #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read pipeline is cleared by reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      rdata <= '0;
    end else begin
      rd_q  <= mem[addr];
      rdata <= rd_q;
    end
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: edge trigger, one-shot capture into sample RAM,
// zoomed readout. Define LA_PRETRIG_EN to keep a pre-trigger ring while armed.
module la_capture_core
  import la_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 13,
  parameter int ZOOM_W     = 4,
  parameter int PRETRIG    = (2**DEPTH_LOG2) / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CHANNELS-1:0]            datain,
  input  logic [sel_width(CHANNELS)-1:0] trig_ch,
  input  logic [1:0]                     trig_mode,
  la_capture_core_if.slave               rd,
  output logic                           armed,
  output logic                           capturing,
  output logic                           done
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("la_capture_core: CHANNELS must be 1..16");
  end
  if (PRETRIG < 1 || PRETRIG >= DEPTH) begin : g_bad_pretrig
    $error("la_capture_core: PRETRIG must be 1..DEPTH-1");
  end

`ifdef LA_PRETRIG_EN
  localparam logic [DEPTH_LOG2-1:0] PRE_L    = PRETRIG;
  localparam logic [DEPTH_LOG2-1:0] CAP_LAST = DEPTH - PRETRIG - 1;
`else
  localparam logic [DEPTH_LOG2-1:0] CAP_LAST = DEPTH - 1;
`endif

  la_state_t             state, state_nx;
  logic [CHANNELS-1:0]   sample_d;
  logic [DEPTH_LOG2-1:0] wptr, cap_cnt, base, rd_addr, ram_addr, shifted;
  logic [CHANNELS-1:0]   ram_q;
  logic [1:0]            rd_v;
  logic                  cur, prev, edge_seen, trig_ok, trigger;
  logic                  arm_go, we, rd_en;

  // Delayed copy loads every cycle, including the arming cycle, so the first
  // ARMED cycle compares against a real previous sample.
  always_ff @(posedge clk) begin
    sample_d <= datain;
  end

  assign cur  = datain[trig_ch];
  assign prev = sample_d[trig_ch];

  always_comb begin
    edge_seen = 1'b0;
    case (trig_mode_t'(trig_mode))
      TRIG_RISE:   edge_seen = cur & ~prev;
      TRIG_FALL:   edge_seen = ~cur & prev;
      TRIG_EITHER: edge_seen = cur ^ prev;
      default:     edge_seen = 1'b1;
    endcase
  end

`ifdef LA_PRETRIG_EN
  logic [DEPTH_LOG2-1:0] fill;
  assign trig_ok = (fill >= PRE_L);
`else
  assign trig_ok = 1'b1;
  assign base    = '0;
`endif

  assign trigger = (state == S_ARMED) && edge_seen && trig_ok;
  assign arm_go  = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    armed     = 1'b0;
    capturing = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_ARMED;
      end
      S_ARMED: begin
        armed = 1'b1;
`ifdef LA_PRETRIG_EN
        we = 1'b1;
`endif
        if (trigger) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        capturing = 1'b1;
        we        = 1'b1;
        if (cap_cnt == CAP_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        done  = 1'b1;
        rd_en = rd.rd_req && !start;
        if (start) state_nx = S_ARMED;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The RAM writes the delayed sample, so the first CAPTURE write is the
  // sample that fired the trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      cap_cnt <= '0;
`ifdef LA_PRETRIG_EN
      fill    <= '0;
      base    <= '0;
`endif
    end else if (arm_go) begin
      wptr    <= '0;
      cap_cnt <= '0;
`ifdef LA_PRETRIG_EN
      fill    <= '0;
`endif
    end else begin
      if (we) wptr <= wptr + ONE;
      if (state == S_CAPTURE) cap_cnt <= cap_cnt + ONE;
`ifdef LA_PRETRIG_EN
      if ((state == S_ARMED) && (fill != PRE_L)) fill <= fill + ONE;
      if (trigger) base <= wptr + ONE - PRE_L;
`endif
    end
  end

  assign shifted  = rd.rd_idx << rd.zoom;
  assign rd_addr  = base + rd.offset + shifted;
  assign ram_addr = we ? wptr : rd_addr;

  la_sample_ram #(
    .WIDTH (CHANNELS),
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .addr (ram_addr),
    .wdata(sample_d),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) rd_v <= '0;
    else       rd_v <= {rd_v[0], rd_en};
  end

  assign rd.rd_valid = rd_v[1];
  assign rd.dout     = rd_v[1] ? ram_q : '0;

endmodule
